// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one N-bit register write port.
// Each grant is a single registered cycle; the winner is masked for the following cycle.
module reg_write_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] wdata,
  input  logic              stall,
  output logic [NREQ-1:0]   gnt,
  output logic              reg_en,
  output logic [N-1:0]      reg_in,
  output logic [IW-1:0]     owner,
  output logic              owner_vld
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              regEn_q, regEn_d;
  logic [N-1:0]      regIn_q, regIn_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              ownerVld_q, ownerVld_d;
  logic [IW-1:0]     ptr_q, ptr_d;

  logic [NREQ-1:0]   mask;
  logic [NREQ-1:0]   elig;
  logic              found;
  logic [IW-1:0]     win;
  logic [IW:0]       scanSum;
  logic [IW-1:0]     scanIdx;

  // Every output and the round-robin pointer are registered; reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      regEn_q    <= 1'b0;
      regIn_q    <= '0;
      owner_q    <= '0;
      ownerVld_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      regEn_q    <= regEn_d;
      regIn_q    <= regIn_d;
      owner_q    <= owner_d;
      ownerVld_q <= ownerVld_d;
      ptr_q      <= ptr_d;
    end
  end

  // Scan eligible requesters starting at the pointer, wrapping at NREQ-1, and pick the first hit.
  always_comb begin
    mask    = (state_q == GRANT) ? gnt_q : '0;
    elig    = req & ~mask;
    found   = 1'b0;
    win     = '0;
    scanSum = '0;
    scanIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scanSum = {1'b0, ptr_q} + (IW+1)'(i);
      if (scanSum >= (IW+1)'(NREQ)) begin
        scanSum = scanSum - (IW+1)'(NREQ);
      end
      scanIdx = scanSum[IW-1:0];
      if (!found && elig[scanIdx]) begin
        found = 1'b1;
        win   = scanIdx;
      end
    end
  end

  // Stall or no eligible request parks the FSM in IDLE; reg_in and owner keep their last values.
  always_comb begin
    state_d    = IDLE;
    gnt_d      = '0;
    regEn_d    = 1'b0;
    regIn_d    = regIn_q;
    owner_d    = owner_q;
    ownerVld_d = ownerVld_q;
    ptr_d      = ptr_q;
    if (!stall && found) begin
      state_d      = GRANT;
      gnt_d[win]   = 1'b1;
      regEn_d      = 1'b1;
      regIn_d      = wdata[int'(win)*N +: N];
      owner_d      = win;
      ownerVld_d   = 1'b1;
      ptr_d        = (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
    end
  end

  assign gnt       = gnt_q;
  assign reg_en    = regEn_q;
  assign reg_in    = regIn_q;
  assign owner     = owner_q;
  assign owner_vld = ownerVld_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios with hand-computed
// grants, then a randomised run compared cycle by cycle against a small behavioural model.
module tb_reg_write_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IW   = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] wdata;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic              reg_en;
  logic [N-1:0]      reg_in;
  logic [IW-1:0]     owner;
  logic              owner_vld;

  int checks = 0;
  int errors = 0;

  // Behavioural model state for the random phase
  logic [NREQ-1:0] mGnt;
  logic            mGrant;
  logic [N-1:0]    mRegIn;
  logic [IW-1:0]   mOwner;
  logic            mVld;
  int              mPtr;
  logic [NREQ-1:0] pending;
  int              waitCnt [NREQ];
  int              maxWait;

  reg_write_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wdata     (wdata),
    .stall     (stall),
    .gnt       (gnt),
    .reg_en    (reg_en),
    .reg_in    (reg_in),
    .owner     (owner),
    .owner_vld (owner_vld)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic s);
    req   = r;
    stall = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic checkGrant(input string tag, input logic [NREQ-1:0] g, input logic [N-1:0] d,
                            input logic [IW-1:0] o);
    checkOutput({tag, ".gnt"}, 64'(gnt), 64'(g));
    checkOutput({tag, ".en"}, 64'(reg_en), 64'(|g));
    checkOutput({tag, ".in"}, 64'(reg_in), 64'(d));
    checkOutput({tag, ".owner"}, 64'(owner), 64'(o));
  endtask

  // Model one clock edge from the inputs currently applied.
  task automatic modelStep();
    logic [NREQ-1:0] elig;
    int w;
    elig = req & ~(mGrant ? mGnt : '0);
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && elig[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
    end
    if (stall || w < 0) begin
      mGnt   = '0;
      mGrant = 1'b0;
    end else begin
      mGnt    = '0;
      mGnt[w] = 1'b1;
      mGrant  = 1'b1;
      mRegIn  = wdata[w*N +: N];
      mOwner  = IW'(w);
      mVld    = 1'b1;
      mPtr    = (w + 1) % NREQ;
    end
  endtask

  initial begin
    logic [NREQ-1:0] prevReq;
    logic            prevStall;

    rst   = 1'b1;
    req   = '0;
    stall = 1'b0;
    wdata = '0;
    #2;
    checkOutput("rst.gnt", 64'(gnt), 64'h0);
    checkOutput("rst.en", 64'(reg_en), 64'h0);
    checkOutput("rst.in", 64'(reg_in), 64'h0);
    checkOutput("rst.owner", 64'(owner), 64'h0);
    checkOutput("rst.vld", 64'(owner_vld), 64'h0);

    // Single request: one-cycle pulse, then data and owner hold
    tick();
    rst = 1'b0;
    wdata[0*N +: N] = 32'hA5A5_0001;
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkGrant("t1c1", 4'b0001, 32'hA5A5_0001, 2'd0);
    checkOutput("t1c1.vld", 64'(owner_vld), 64'h1);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkGrant("t1c2", 4'b0000, 32'hA5A5_0001, 2'd0);

    // All requesting: rotation with wrap 3 -> 0
    doReset();
    for (int i = 0; i < NREQ; i++) wdata[i*N +: N] = 32'h1111_0000 + 32'(i);
    applyStimulus(4'b1111, 1'b0);
    tick(); checkGrant("t2a", 4'b0001, 32'h1111_0000, 2'd0);
    tick(); checkGrant("t2b", 4'b0010, 32'h1111_0001, 2'd1);
    tick(); checkGrant("t2c", 4'b0100, 32'h1111_0002, 2'd2);
    tick(); checkGrant("t2d", 4'b1000, 32'h1111_0003, 2'd3);
    tick(); checkGrant("t2e", 4'b0001, 32'h1111_0000, 2'd0);

    // Sole continuous requester alternates grant / idle
    doReset();
    wdata[2*N +: N] = 32'hCAFE_0002;
    applyStimulus(4'b0100, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      checkGrant($sformatf("t3c%0d", c), (c % 2 == 0) ? 4'b0100 : 4'b0000, 32'hCAFE_0002, 2'd2);
    end

    // Stall holds off grants; pointer unchanged afterwards
    doReset();
    wdata[1*N +: N] = 32'hBEEF_0001;
    wdata[3*N +: N] = 32'hBEEF_0003;
    applyStimulus(4'b1010, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("t4s%0d.gnt", c), 64'(gnt), 64'h0);
    end
    checkOutput("t4s.vld", 64'(owner_vld), 64'h0);
    applyStimulus(4'b1010, 1'b0);
    tick(); checkGrant("t4a", 4'b0010, 32'hBEEF_0001, 2'd1);
    tick(); checkGrant("t4b", 4'b1000, 32'hBEEF_0003, 2'd3);
    tick(); checkGrant("t4c", 4'b0010, 32'hBEEF_0001, 2'd1);

    // Async reset mid-grant clears everything before the next edge, pointer back to 0
    doReset();
    wdata[2*N +: N] = 32'h0000_D002;
    wdata[3*N +: N] = 32'h0000_D003;
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkGrant("t5pre", 4'b0100, 32'h0000_D002, 2'd2);
    rst = 1'b1;
    #1;
    checkGrant("t5rst", 4'b0000, 32'h0, 2'd0);
    checkOutput("t5rst.vld", 64'(owner_vld), 64'h0);
    tick();
    rst = 1'b0;
    applyStimulus(4'b1100, 1'b0);
    tick();
    checkGrant("t5post", 4'b0100, 32'h0000_D002, 2'd2);

    // Randomised traffic against the model, requesters honouring the hold-until-granted handshake
    doReset();
    mGnt = '0; mGrant = 1'b0; mRegIn = '0; mOwner = '0; mVld = 1'b0; mPtr = 0;
    pending = '0;
    maxWait = 0;
    for (int i = 0; i < NREQ; i++) waitCnt[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) pending[i] = 1'b0;
        if (!pending[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          wdata[i*N +: N] = $urandom;
          pending[i] = req[i];
        end
      end
      stall = ($urandom_range(0, 4) == 0);
      prevReq = req;
      prevStall = stall;
      modelStep();
      tick();
      checkOutput("rnd.gnt", 64'(gnt), 64'(mGnt));
      checkOutput("rnd.en", 64'(reg_en), 64'(|mGnt));
      checkOutput("rnd.in", 64'(reg_in), 64'(mRegIn));
      checkOutput("rnd.owner", 64'(owner), 64'(mOwner));
      checkOutput("rnd.vld", 64'(owner_vld), 64'(mVld));
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) waitCnt[i] = 0;
        else if (prevReq[i] && !prevStall) waitCnt[i]++;
        if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
      end
    end
    checkOutput("rnd.starve", 64'(maxWait > 2*NREQ), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
